audio_mixer_dac: RTL and testbench

//  Mixes two AY/YM chips (6x8-bit channels), beeper, tape in/out and 4 Soundrive DAC channels into stereo 12-bit samples.

---
 rtl/audio_mixer_dac_if.sv | 22 ++
 rtl/audio_mixer_dac.sv | 88 ++++++++
 tb/tb_audio_mixer_dac.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_dac_if.sv
// audio_mixer_dac_if: sound source levels in, latched stereo mix and sigma-delta bitstreams out
interface audio_mixer_dac_if;
  logic [7:0]  ay_a0, ay_a1, ay_b0, ay_b1, ay_c0, ay_c1;
  logic [1:0]  ay_mode;
  logic        beeper, tape_out, tape_in;
  logic        sd_en;
  logic [7:0]  sd_l0, sd_l1, sd_r0, sd_r1;
  logic        mute;
  logic [11:0] mix_l, mix_r;
  logic        sample_stb;
  logic        dac_l, dac_r;
  modport slave (
    input  ay_a0, ay_a1, ay_b0, ay_b1, ay_c0, ay_c1, ay_mode, beeper, tape_out, tape_in,
           sd_en, sd_l0, sd_l1, sd_r0, sd_r1, mute,
    output mix_l, mix_r, sample_stb, dac_l, dac_r
  );
  modport master (
    output ay_a0, ay_a1, ay_b0, ay_b1, ay_c0, ay_c1, ay_mode, beeper, tape_out, tape_in,
           sd_en, sd_l0, sd_l1, sd_r0, sd_r1, mute,
    input  mix_l, mix_r, sample_stb, dac_l, dac_r
  );
endinterface

// File: rtl/audio_mixer_dac.sv
// audio_mixer_dac: 16-slot time-multiplexed stereo mixer with first-order sigma-delta outputs
module audio_mixer_dac #(
  parameter logic [7:0] BEEPER_VOL  = 8'd192,
  parameter logic [7:0] TAPEOUT_VOL = 8'd64,
  parameter logic [7:0] TAPEIN_VOL  = 8'd32
) (
  input  logic clk28,
  input  logic rst,
  audio_mixer_dac_if.slave bus
);
  logic [3:0]  seq_q;
  logic [11:0] acc_l_q, acc_r_q, mix_l_q, mix_r_q, sd_l_q, sd_r_q;
  logic        stb_q, dac_l_q, dac_r_q;
  logic [7:0]  ay [8];
  logic [7:0]  ch, add_l, add_r;
  logic [1:0]  grp;
  logic        mid;
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [7:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[12] ? 12'hfff : s[11:0];
  endfunction
  // slots 0..5 walk A0,A1,B0,B1,C0,C1; the centre channel (or all in mono) is halved onto both sides
  always_comb begin
    ay = '{bus.ay_a0, bus.ay_a1, bus.ay_b0, bus.ay_b1, bus.ay_c0, bus.ay_c1, 8'd0, 8'd0};
    ch = ay[seq_q[2:0]];
    grp = seq_q[2:1];
    mid = (bus.ay_mode == 2'b00) | (grp == ((bus.ay_mode == 2'b10) ? 2'd2 : 2'd1));
    add_l = '0;
    add_r = '0;
    case (seq_q)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        add_l = mid ? {1'b0, ch[7:1]} : ((grp == 2'd0) ? ch : 8'd0);
        add_r = mid ? {1'b0, ch[7:1]} : ((grp == 2'd0) ? 8'd0 : ch);
      end
      4'd6: begin
        add_l = bus.beeper ? BEEPER_VOL : 8'd0;
        add_r = add_l;
      end
      4'd7: begin
        add_l = bus.tape_out ? TAPEOUT_VOL : 8'd0;
        add_r = add_l;
      end
      4'd8: begin
        add_l = bus.tape_in ? TAPEIN_VOL : 8'd0;
        add_r = add_l;
      end
      4'd9:  add_l = bus.sd_en ? bus.sd_l0 : 8'd0;
      4'd10: add_l = bus.sd_en ? bus.sd_l1 : 8'd0;
      4'd11: add_r = bus.sd_en ? bus.sd_r0 : 8'd0;
      4'd12: add_r = bus.sd_en ? bus.sd_r1 : 8'd0;
      default: ;
    endcase
  end
  always_ff @(posedge clk28) begin
    if (rst) begin
      seq_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      mix_l_q <= '0;
      mix_r_q <= '0;
      sd_l_q  <= '0;
      sd_r_q  <= '0;
      stb_q   <= 1'b0;
      dac_l_q <= 1'b0;
      dac_r_q <= 1'b0;
    end else begin
      seq_q <= seq_q + 4'd1;
      stb_q <= (seq_q == 4'd15);
      if (seq_q == 4'd15) begin
        mix_l_q <= bus.mute ? 12'd0 : acc_l_q;
        mix_r_q <= bus.mute ? 12'd0 : acc_r_q;
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else begin
        acc_l_q <= sat_add(acc_l_q, add_l);
        acc_r_q <= sat_add(acc_r_q, add_r);
      end
      {dac_l_q, sd_l_q} <= {1'b0, sd_l_q} + {1'b0, mix_l_q};
      {dac_r_q, sd_r_q} <= {1'b0, sd_r_q} + {1'b0, mix_r_q};
    end
  end
  assign bus.mix_l      = mix_l_q;
  assign bus.mix_r      = mix_r_q;
  assign bus.sample_stb = stb_q;
  assign bus.dac_l      = dac_l_q;
  assign bus.dac_r      = dac_r_q;
endmodule

// File: tb/tb_audio_mixer_dac.sv
// tb_audio_mixer_dac: directed and randomized checks of the mixer against an arithmetic reference model
module tb_audio_mixer_dac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  audio_mixer_dac_if bus();
  audio_mixer_dac dut (.clk28(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic clear_inputs();
    bus.ay_a0 = 0; bus.ay_a1 = 0; bus.ay_b0 = 0; bus.ay_b1 = 0; bus.ay_c0 = 0; bus.ay_c1 = 0;
    bus.ay_mode = 2'b01; bus.beeper = 0; bus.tape_out = 0; bus.tape_in = 0;
    bus.sd_en = 0; bus.sd_l0 = 0; bus.sd_l1 = 0; bus.sd_r0 = 0; bus.sd_r1 = 0; bus.mute = 0;
  endtask
  function automatic void model(output int l, output int r);
    int a [6];
    int centre;
    a = '{int'(bus.ay_a0), int'(bus.ay_a1), int'(bus.ay_b0), int'(bus.ay_b1), int'(bus.ay_c0), int'(bus.ay_c1)};
    centre = (bus.ay_mode == 2'b10) ? 2 : 1;
    l = 0;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ay_mode == 2'b00 || i / 2 == centre) begin
        l += a[i] / 2;
        r += a[i] / 2;
      end else if (i / 2 == 0) l += a[i];
      else r += a[i];
    end
    l += (bus.beeper ? 192 : 0) + (bus.tape_out ? 64 : 0) + (bus.tape_in ? 32 : 0);
    r += (bus.beeper ? 192 : 0) + (bus.tape_out ? 64 : 0) + (bus.tape_in ? 32 : 0);
    if (bus.sd_en) begin
      l += int'(bus.sd_l0) + int'(bus.sd_l1);
      r += int'(bus.sd_r0) + int'(bus.sd_r1);
    end
    if (l > 4095) l = 4095;
    if (r > 4095) r = 4095;
    if (bus.mute) begin
      l = 0;
      r = 0;
    end
  endfunction
  task automatic wait_stb(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.sample_stb && cyc < 64);
    n_checks++;
    if (!bus.sample_stb) begin
      $display("FAIL stb_timeout: no sample_stb within %0d cycles", cyc);
      n_fail++;
    end
  endtask
  task automatic frame_check(input string name);
    int cyc, el, er;
    wait_stb(cyc);
    wait_stb(cyc);
    model(el, er);
    n_checks++;
    if (bus.mix_l !== 12'(el)) begin
      $display("FAIL %s mix_l: got %0d expected %0d", name, bus.mix_l, el);
      n_fail++;
    end
    n_checks++;
    if (bus.mix_r !== 12'(er)) begin
      $display("FAIL %s mix_r: got %0d expected %0d", name, bus.mix_r, er);
      n_fail++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.mix_l, bus.mix_r, bus.sample_stb, bus.dac_l, bus.dac_r} !== 27'd0) begin
      $display("FAIL reset_outputs: got mix_l=%0d mix_r=%0d stb=%b dac=%b%b expected all 0",
               bus.mix_l, bus.mix_r, bus.sample_stb, bus.dac_l, bus.dac_r);
      n_fail++;
    end
    rst = 1'b0;
  endtask
  task automatic test_abc_dac();
    int ones_l = 0, ones_r = 0;
    clear_inputs();
    bus.ay_a0 = 200;
    frame_check("abc_a0");
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ones_l += int'(bus.dac_l);
      ones_r += int'(bus.dac_r);
    end
    n_checks++;
    if (ones_l != 200) begin
      $display("FAIL dac_l_density: got %0d ones expected 200", ones_l);
      n_fail++;
    end
    n_checks++;
    if (ones_r != 0) begin
      $display("FAIL dac_r_density: got %0d ones expected 0", ones_r);
      n_fail++;
    end
  endtask
  task automatic test_mono_acb();
    clear_inputs();
    bus.ay_mode = 2'b00; bus.ay_a0 = 200; bus.ay_b1 = 101;
    frame_check("mono");
    clear_inputs();
    bus.ay_mode = 2'b10; bus.ay_b0 = 100; bus.ay_c0 = 80;
    frame_check("acb");
    bus.ay_mode = 2'b11;
    frame_check("mode11");
  endtask
  task automatic test_full_scale();
    clear_inputs();
    {bus.ay_a0, bus.ay_a1, bus.ay_b0, bus.ay_b1, bus.ay_c0, bus.ay_c1} = '1;
    {bus.beeper, bus.tape_out, bus.tape_in, bus.sd_en} = 4'hf;
    {bus.sd_l0, bus.sd_l1, bus.sd_r0, bus.sd_r1} = '1;
    frame_check("full_scale");
    n_checks++;
    if (bus.mix_l !== 12'd1562 || bus.mix_r !== 12'd1562) begin
      $display("FAIL full_scale_const: got %0d/%0d expected 1562/1562", bus.mix_l, bus.mix_r);
      n_fail++;
    end
  endtask
  task automatic test_sd_en_mute();
    int cyc;
    clear_inputs();
    bus.sd_l0 = 255; bus.sd_r1 = 77;
    frame_check("sd_disabled");
    clear_inputs();
    bus.ay_a0 = 200; bus.mute = 1;
    frame_check("mute_on");
    bus.mute = 0;
    wait_stb(cyc);
    n_checks++;
    if (bus.mix_l !== 12'd200) begin
      $display("FAIL mute_release: got %0d expected 200", bus.mix_l);
      n_fail++;
    end
  endtask
  task automatic test_reset_mid();
    int cyc;
    clear_inputs();
    bus.ay_a0 = 200;
    frame_check("pre_reset");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.mix_l, bus.mix_r, bus.sample_stb, bus.dac_l, bus.dac_r} !== 27'd0) begin
      $display("FAIL mid_reset_outputs: got mix_l=%0d mix_r=%0d stb=%b dac=%b%b expected all 0",
               bus.mix_l, bus.mix_r, bus.sample_stb, bus.dac_l, bus.dac_r);
      n_fail++;
    end
    rst = 1'b0;
    wait_stb(cyc);
    n_checks++;
    if (cyc != 16) begin
      $display("FAIL reset_to_stb: got %0d cycles expected 16", cyc);
      n_fail++;
    end
    n_checks++;
    if (bus.mix_l !== 12'd200 || bus.mix_r !== 12'd0) begin
      $display("FAIL post_reset_mix: got %0d/%0d expected 200/0", bus.mix_l, bus.mix_r);
      n_fail++;
    end
  endtask
  task automatic test_mid_change();
    int cyc;
    clear_inputs();
    bus.ay_a0 = 10;
    frame_check("a0_10");
    repeat (3) @(negedge clk);
    bus.ay_a0 = 250;
    wait_stb(cyc);
    n_checks++;
    if (cyc != 13 || bus.mix_l !== 12'd10) begin
      $display("FAIL late_change_cur: got cyc=%0d mix_l=%0d expected 13/10", cyc, bus.mix_l);
      n_fail++;
    end
    wait_stb(cyc);
    n_checks++;
    if (cyc != 16 || bus.mix_l !== 12'd250) begin
      $display("FAIL late_change_next: got cyc=%0d mix_l=%0d expected 16/250", cyc, bus.mix_l);
      n_fail++;
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      bus.ay_a0 = 8'($urandom); bus.ay_a1 = 8'($urandom); bus.ay_b0 = 8'($urandom);
      bus.ay_b1 = 8'($urandom); bus.ay_c0 = 8'($urandom); bus.ay_c1 = 8'($urandom);
      bus.ay_mode = 2'($urandom); bus.beeper = 1'($urandom); bus.tape_out = 1'($urandom);
      bus.tape_in = 1'($urandom); bus.sd_en = 1'($urandom);
      bus.sd_l0 = 8'($urandom); bus.sd_l1 = 8'($urandom); bus.sd_r0 = 8'($urandom); bus.sd_r1 = 8'($urandom);
      bus.mute = ($urandom_range(0, 3) == 0);
      frame_check($sformatf("random%0d", k));
    end
  endtask
  initial begin
    test_reset();
    test_abc_dac();
    test_mono_acb();
    test_full_scale();
    test_sd_en_mute();
    test_reset_mid();
    test_mid_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
